// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths and pointer compare helpers
package fifo_pkg;

  localparam int MAX_PTR_W = 16;

  function automatic int elem_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int ptr_width(input int fifo_size);
    return $clog2(fifo_size) + 1;
  endfunction

  // Full: same slot index, opposite lap (wrap bit differs).
  function automatic logic ptr_full(input logic [MAX_PTR_W-1:0] wr_ptr,
                                    input logic [MAX_PTR_W-1:0] rd_ptr,
                                    input int aw);
    logic [MAX_PTR_W-1:0] low_mask;
    low_mask = (MAX_PTR_W'(1) << (aw - 1)) - MAX_PTR_W'(1);
    return (((wr_ptr ^ rd_ptr) & low_mask) == '0) && (wr_ptr[aw-1] != rd_ptr[aw-1]);
  endfunction

  function automatic logic ptr_empty(input logic [MAX_PTR_W-1:0] wr_ptr,
                                     input logic [MAX_PTR_W-1:0] rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

endpackage

// File: rtl/skew_fifo_bank_if.sv
// rtl/skew_fifo_bank_if.sv - write/read/status bundle of the skewed FIFO bank
interface skew_fifo_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 4
);
  logic                           wr_clr;
  logic                           rd_clr;
  logic [NUM_CH-1:0]              wr_en;
  logic [NUM_CH*2*DATA_WIDTH-1:0] data_in_fifo;
  logic                           rd_en;
  logic [NUM_CH*2*DATA_WIDTH-1:0] data_out_fifo;
  logic [NUM_CH-1:0]              out_valid;
  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH*ADDR_WIDTH-1:0]   count;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output wr_clr, rd_clr, wr_en, data_in_fifo, rd_en,
    input  data_out_fifo, out_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_clr, rd_clr, wr_en, data_in_fifo, rd_en,
    output data_out_fifo, out_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_channel.sv
// rtl/fifo_channel.sv - one circular FIFO with flags and zero-filled registered output
module fifo_channel
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_clr,
  input  logic                            rd_clr,
  input  logic                            wr_en,
  input  logic [elem_width(DATA_WIDTH)-1:0] wr_data,
  input  logic                            rd_req,
  output logic [elem_width(DATA_WIDTH)-1:0] rd_data,
  output logic                            rd_valid,
  output logic                            full,
  output logic                            empty,
  output logic [ADDR_WIDTH-1:0]           count,
  output logic                            ovf_evt,
  output logic                            unf_evt
);
  localparam int EW  = elem_width(DATA_WIDTH);
  localparam int IW  = ADDR_WIDTH - 1;
  localparam int PAD = MAX_PTR_W - ADDR_WIDTH;

  logic [EW-1:0]         mem [FIFO_SIZE];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  rd_fire, wr_fire;

  assign full  = ptr_full({{PAD{1'b0}}, wr_ptr}, {{PAD{1'b0}}, rd_ptr}, ADDR_WIDTH);
  assign empty = ptr_empty({{PAD{1'b0}}, wr_ptr}, {{PAD{1'b0}}, rd_ptr});
  assign count = wr_ptr - rd_ptr;

  // A read freeing a slot lets a write into a full channel in the same cycle.
  assign rd_fire = rd_req && !rd_clr && !empty;
  assign unf_evt = rd_req && !rd_clr && empty;
  assign wr_fire = wr_en && !wr_clr && (!full || rd_fire);
  assign ovf_evt = wr_en && !wr_clr && !wr_fire;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_clr) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_clr) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_fire) begin
      rd_ptr   <= rd_ptr + 1'b1;
      rd_data  <= mem[rd_ptr[IW-1:0]];
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/skew_fifo_bank.sv
// rtl/skew_fifo_bank.sv - FIFO bank with per-channel read skew for the systolic array edge
module skew_fifo_bank
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 4
) (
  input logic              clk,
  input logic              rst_n,
  skew_fifo_bank_if.slave  bus
);
  localparam int EW = elem_width(DATA_WIDTH);

  logic [NUM_CH-1:0]            rd_req;
  logic [NUM_CH-2:0]            skew_q;
  logic [NUM_CH*EW-1:0]         dout_w;
  logic [NUM_CH-1:0]            valid_w, full_w, empty_w, ovf_w, unf_w;
  logic [NUM_CH*ADDR_WIDTH-1:0] count_w;
  logic                         overflow_q, underflow_q;

  assign rd_req[0] = bus.rd_en;

  // Channel c sees the read request c cycles late, forming the diagonal wavefront.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skew_q <= '0;
    end else if (bus.rd_clr) begin
      skew_q <= '0;
    end else begin
      skew_q[0] <= bus.rd_en;
      for (int i = 1; i < NUM_CH - 1; i++) skew_q[i] <= skew_q[i-1];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (c > 0) begin : g_skew
      assign rd_req[c] = skew_q[c-1];
    end

    fifo_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_SIZE (FIFO_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_clr  (bus.wr_clr),
      .rd_clr  (bus.rd_clr),
      .wr_en   (bus.wr_en[c]),
      .wr_data (bus.data_in_fifo[c*EW +: EW]),
      .rd_req  (rd_req[c]),
      .rd_data (dout_w[c*EW +: EW]),
      .rd_valid(valid_w[c]),
      .full    (full_w[c]),
      .empty   (empty_w[c]),
      .count   (count_w[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .ovf_evt (ovf_w[c]),
      .unf_evt (unf_w[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (|ovf_w);
      underflow_q <= underflow_q | (|unf_w);
    end
  end

  assign bus.data_out_fifo = dout_w;
  assign bus.out_valid     = valid_w;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.count         = count_w;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_skew_fifo_bank.sv
// tb/tb_skew_fifo_bank.sv - directed table and sequence checks for skew_fifo_bank
module tb_skew_fifo_bank;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  skew_fifo_bank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_CH(4)) bus ();

  skew_fifo_bank #(
    .DATA_WIDTH(8),
    .FIFO_SIZE (16),
    .ADDR_WIDTH(5),
    .NUM_CH    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  wr_en;
    logic [63:0] din;
    logic        rd_en;
    logic [3:0]  exp_valid;
    logic [63:0] exp_dout;
    logic [3:0]  exp_empty;
    logic [19:0] exp_count;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [3:0] we, input logic [63:0] din, input logic re,
                              input logic [3:0] ev, input logic [63:0] ed,
                              input logic [3:0] ee, input logic [19:0] ec);
    vec_t v;
    v.wr_en = we; v.din = din; v.rd_en = re;
    v.exp_valid = ev; v.exp_dout = ed; v.exp_empty = ee; v.exp_count = ec;
    return v;
  endfunction

  function automatic logic [63:0] lanes(input logic [15:0] k);
    return {16'h0300 + k, 16'h0200 + k, 16'h0100 + k, k};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.wr_clr = 1'b1;
    bus.rd_clr = 1'b1;
    step();
    bus.wr_clr = 1'b0;
    bus.rd_clr = 1'b0;
    chk("clr_empty", 64'(bus.empty), 64'hF);
    chk("clr_count", 64'(bus.count), 64'h0);
    chk("clr_valid", 64'(bus.out_valid), 64'h0);
  endtask

  task automatic wr0(input logic [15:0] val);
    bus.wr_en        = 4'b0001;
    bus.data_in_fifo = {48'h0, val};
    step();
    bus.wr_en        = 4'b0000;
  endtask

  task automatic rd0_seq(input string name, input int n, input int first);
    for (int i = 0; i < n; i++) begin
      bus.rd_en = 1'b1;
      step();
      chk(name, {47'h0, bus.out_valid[0], bus.data_out_fifo[15:0]},
          {47'h0, 1'b1, 16'(first + i)});
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {bus.data_out_fifo, 4'h0, bus.out_valid, bus.empty, bus.full},
        {64'h0, 4'h0, 4'h0, 4'hF, 4'h0});
    chk(name, {42'h0, bus.count, bus.overflow, bus.underflow}, 64'h0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.wr_clr       = 1'b0;
    bus.rd_clr       = 1'b0;
    bus.wr_en        = 4'h0;
    bus.data_in_fifo = '0;
    bus.rd_en        = 1'b0;

    vecs[0]  = mk(4'hF, lanes(1), 0, 4'h0, 64'h0, 4'h0, {5'd1, 5'd1, 5'd1, 5'd1});
    vecs[1]  = mk(4'hF, lanes(2), 0, 4'h0, 64'h0, 4'h0, {5'd2, 5'd2, 5'd2, 5'd2});
    vecs[2]  = mk(4'hF, lanes(3), 0, 4'h0, 64'h0, 4'h0, {5'd3, 5'd3, 5'd3, 5'd3});
    vecs[3]  = mk(4'hF, lanes(4), 0, 4'h0, 64'h0, 4'h0, {5'd4, 5'd4, 5'd4, 5'd4});
    vecs[4]  = mk(4'h0, 64'h0, 1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0001},
                  4'h0, {5'd4, 5'd4, 5'd4, 5'd3});
    vecs[5]  = mk(4'h0, 64'h0, 1, 4'b0011, {16'h0, 16'h0, 16'h0101, 16'h0002},
                  4'h0, {5'd4, 5'd4, 5'd3, 5'd2});
    vecs[6]  = mk(4'h0, 64'h0, 1, 4'b0111, {16'h0, 16'h0201, 16'h0102, 16'h0003},
                  4'h0, {5'd4, 5'd3, 5'd2, 5'd1});
    vecs[7]  = mk(4'h0, 64'h0, 1, 4'b1111, {16'h0301, 16'h0202, 16'h0103, 16'h0004},
                  4'b0001, {5'd3, 5'd2, 5'd1, 5'd0});
    vecs[8]  = mk(4'h0, 64'h0, 0, 4'b1110, {16'h0302, 16'h0203, 16'h0104, 16'h0},
                  4'b0011, {5'd2, 5'd1, 5'd0, 5'd0});
    vecs[9]  = mk(4'h0, 64'h0, 0, 4'b1100, {16'h0303, 16'h0204, 16'h0, 16'h0},
                  4'b0111, {5'd1, 5'd0, 5'd0, 5'd0});
    vecs[10] = mk(4'h0, 64'h0, 0, 4'b1000, {16'h0304, 16'h0, 16'h0, 16'h0},
                  4'hF, 20'h0);
    vecs[11] = mk(4'h0, 64'h0, 0, 4'h0, 64'h0, 4'hF, 20'h0);

    repeat (2) step();
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Staircase read
    for (int i = 0; i < 12; i++) begin
      bus.wr_en        = vecs[i].wr_en;
      bus.data_in_fifo = vecs[i].din;
      bus.rd_en        = vecs[i].rd_en;
      step();
      chk($sformatf("stair_valid[%0d]", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("stair_dout[%0d]", i), bus.data_out_fifo, vecs[i].exp_dout);
      chk($sformatf("stair_empty[%0d]", i), 64'(bus.empty), 64'(vecs[i].exp_empty));
      chk($sformatf("stair_count[%0d]", i), 64'(bus.count), 64'(vecs[i].exp_count));
    end
    bus.wr_en = 4'h0;
    chk("stair_flags", {62'h0, bus.overflow, bus.underflow}, 64'h0);

    // Empty read: no data, sticky underflow, pointers untouched
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("empty_rd_out", {bus.data_out_fifo[59:0], bus.out_valid}, 64'h0);
      step();
    end
    chk("empty_rd_unf", 64'(bus.underflow), 64'h1);
    chk("empty_rd_cnt", {39'h0, bus.count, bus.empty, 1'b0}, {39'h0, 20'h0, 4'hF, 1'b0});

    // Full channel accepts a write alongside a read
    clear_all();
    for (int i = 1; i <= 16; i++) wr0(16'(i));
    chk("full_rw_pre", {58'h0, bus.full[0], bus.count[4:0]}, {58'h0, 1'b1, 5'd16});
    bus.wr_en        = 4'b0001;
    bus.data_in_fifo = {48'h0, 16'd99};
    bus.rd_en        = 1'b1;
    step();
    bus.wr_en = 4'h0;
    bus.rd_en = 1'b0;
    chk("full_rw_rd", {47'h0, bus.out_valid[0], bus.data_out_fifo[15:0]}, {47'h0, 1'b1, 16'd1});
    chk("full_rw_st", {57'h0, bus.overflow, bus.full[0], bus.count[4:0]},
        {57'h0, 1'b0, 1'b1, 5'd16});
    rd0_seq("full_rw_drain", 15, 2);
    rd0_seq("full_rw_99", 1, 99);
    step();
    chk("full_rw_end", {59'h0, bus.count[4:0]}, 64'h0);

    // Full and overflow
    clear_all();
    for (int i = 1; i <= 15; i++) wr0(16'(i));
    chk("ovf_15", {58'h0, bus.full[0], bus.count[4:0]}, {58'h0, 1'b0, 5'd15});
    wr0(16'd16);
    chk("ovf_16", {57'h0, bus.overflow, bus.full[0], bus.count[4:0]},
        {57'h0, 1'b0, 1'b1, 5'd16});
    wr0(16'd17);
    chk("ovf_17", {57'h0, bus.overflow, bus.full[0], bus.count[4:0]},
        {57'h0, 1'b1, 1'b1, 5'd16});
    rd0_seq("ovf_read", 16, 1);
    chk("ovf_empty", 64'(bus.empty[0]), 64'h1);

    // Wrap-around preserves order
    clear_all();
    for (int i = 1; i <= 16; i++) wr0(16'(i));
    rd0_seq("wrap_rd10", 10, 1);
    for (int i = 17; i <= 26; i++) wr0(16'(i));
    chk("wrap_full", {58'h0, bus.full[0], bus.count[4:0]}, {58'h0, 1'b1, 5'd16});
    rd0_seq("wrap_rd16", 16, 11);
    chk("wrap_end", {58'h0, bus.empty[0], bus.count[4:0]}, {58'h0, 1'b1, 5'd0});

    // Reset in the middle of a read burst
    for (int i = 1; i <= 4; i++) wr0(16'(i));
    bus.rd_en = 1'b1;
    step();
    chk("rst_burst_pre", {47'h0, bus.out_valid[0], bus.data_out_fifo[15:0]},
        {47'h0, 1'b1, 16'd1});
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    step();
    bus.rd_en = 1'b0;
    rst_n     = 1'b1;
    wr0(16'hABCD);
    chk("rst_after_wr", {59'h0, bus.empty[0], bus.count[4:0]}, {59'h0, 1'b0, 5'd1});
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("rst_after_rd", {47'h0, bus.out_valid[0], bus.data_out_fifo[15:0]},
        {47'h0, 1'b1, 16'hABCD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
